// File: rtl/wb_data_cache_pkg.sv
// Shared definitions for the write-back data cache: FSM state type, default
// geometry and address-splitting helpers.
//   cache_state_t : IDLE / WRITEBACK / ALLOCATE / UPDATE
//   TAG_W, IDX_W  : tag / index widths for the default 8-set geometry
//   BLOCK_W       : memory block width (four 32-bit words)
package wb_data_cache_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TAG_W   = 32 - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    UPDATE
  } cache_state_t;

  // Tag = everything above the 4-bit block offset and the index field.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned idx_w);
    return addr >> (4 + idx_w);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned idx_w);
    return (addr >> 4) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [1:0] addr_word(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/wb_data_cache_cache_line_array.sv
// Line storage for the direct-mapped cache: per-set valid, dirty, tag and
// data block.
//   idx                 : set selected for every port below
//   rd_*                : asynchronous read of the selected set
//   word_we/word_*      : synchronous single-word store, marks the line dirty
//   fill_en/fill_*      : synchronous whole-line refill, line becomes clean+valid
//   reset (active-low)  : asynchronously invalidates and cleans every line
module cache_line_array
  import wb_data_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned TAG_W    = 25,
  parameter int unsigned LINE_W   = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_block,
  input  logic              word_we,
  input  logic [1:0]        word_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_block
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [LINE_W-1:0]   data_d [NUM_SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_block = data_q[idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
      data_d[idx]  = fill_block;
    end else if (word_we) begin
      data_d[idx][{word_sel, 5'b0} +: WORD_W] = word_data;
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags and data are qualified by valid, so they need no reset.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/wb_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache on the CPU load/store
// port. Hits complete combinationally; misses raise busywait while the FSM
// writes back a dirty victim and refills the line over a 128-bit block bus.
//   clock, reset (active-low, async)
//   read/write/address/writedata -> readdata/busywait     : CPU side
//   mem_read/mem_write/mem_address/mem_writedata,
//   mem_readdata/mem_busywait                              : memory side
module wb_data_cache
  import wb_data_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS        = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  localparam int unsigned SET_W  = $clog2(NUM_SETS);
  localparam int unsigned LTAG_W = 28 - SET_W;
  localparam int unsigned LINE_W = WORDS_PER_BLOCK * WORD_W;

  logic [31:0]       tag_full, idx_full;
  logic [LTAG_W-1:0] req_tag;
  logic [SET_W-1:0]  req_idx;
  logic [1:0]        req_word;
  logic              unused_addr_bits;

  assign tag_full = addr_tag(address, SET_W);
  assign idx_full = addr_index(address, SET_W);
  assign req_tag  = tag_full[LTAG_W-1:0];
  assign req_idx  = idx_full[SET_W-1:0];
  assign req_word = addr_word(address);
  assign unused_addr_bits = ^{tag_full[31:LTAG_W], idx_full[31:SET_W], address[1:0]};

  logic              line_valid, line_dirty;
  logic [LTAG_W-1:0] line_tag;
  logic [LINE_W-1:0] line_block;
  logic              word_we, fill_en;

  cache_state_t      state_q, state_d;
  logic              wb_seen_q, wb_seen_d;
  logic [LINE_W-1:0] refill_q, refill_d;

  logic req, hit;

  assign req = read | write;
  assign hit = line_valid && (line_tag == req_tag);

  cache_line_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (SET_W),
    .TAG_W    (LTAG_W),
    .LINE_W   (LINE_W)
  ) u_lines (
    .clock      (clock),
    .reset      (reset),
    .idx        (req_idx),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .rd_tag     (line_tag),
    .rd_block   (line_block),
    .word_we    (word_we),
    .word_sel   (req_word),
    .word_data  (writedata),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_block (refill_q)
  );

  // readdata is forced to zero outside a read hit so that it reads 0 out of
  // reset and never exposes stale line contents during a miss.
  always_comb begin
    state_d       = state_q;
    wb_seen_d     = 1'b0;
    refill_d      = refill_q;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = address[31:4];
    mem_writedata = line_block;
    word_we       = 1'b0;
    fill_en       = 1'b0;
    readdata      = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (write) word_we  = 1'b1;
            else       readdata = line_block[{req_word, 5'b0} +: WORD_W];
          end else begin
            busywait = 1'b1;
            state_d  = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        busywait    = 1'b1;
        mem_write   = 1'b1;
        mem_address = {line_tag, req_idx};
        wb_seen_d   = 1'b1;
        // First cycle is ignored: memory may not have raised busy yet.
        if (wb_seen_q && !mem_busywait) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) begin
          refill_d = mem_readdata;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        busywait = 1'b1;
        fill_en  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wb_seen_q <= 1'b0;
      refill_q  <= '0;
    end else begin
      state_q   <= state_d;
      wb_seen_q <= wb_seen_d;
      refill_q  <= refill_d;
    end
  end

endmodule
